// File: rtl/vgafb_pkg.sv
// rtl/vgafb_pkg.sv - shared types and burst geometry for the VGA framebuffer fetch path
package vgafb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_SPACE = 2'd1,
        REQ        = 2'd2,
        DATA       = 2'd3
    } fetch_state_t;

    localparam int VGAFB_BURST_WORDS = 4;
    localparam int VGAFB_BURST_SHIFT = 5;

endpackage

// File: rtl/vgafb_fetch_sched.sv
// rtl/vgafb_fetch_sched.sv - per-frame FML burst fetch scheduler feeding the pixel FIFO
// Optional underrun counter (underruns/stats_clr) built when VGAFB_FETCH_STATS_EN is defined.
module vgafb_fetch_sched
    import vgafb_pkg::*;
#(
    parameter int fml_depth   = 26,
    parameter int fifo_depth  = 64,
    parameter int fifo_thresh = 8
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic                        vga_rst,
    input  logic                        frame_start,
    input  logic [31:0]                 baseaddress,
    output logic                        baseaddress_ack,
    input  logic [18:0]                 nbursts,
    output logic [fml_depth-1:0]        fml_adr,
    output logic                        fml_stb,
    input  logic                        fml_ack,
    input  logic [$clog2(fifo_depth):0] fifo_level,
    output logic                        fifo_we,
`ifdef VGAFB_FETCH_STATS_EN
    input  logic                        stats_clr,
    output logic [15:0]                 underruns,
`endif
    output logic                        busy
);

    localparam int LW = $clog2(fifo_depth) + 1;
    // Highest occupancy that still leaves fifo_thresh words free.
    localparam logic [LW-1:0] LEVEL_MAX = LW'(fifo_depth - fifo_thresh);

    fetch_state_t                          state;
    logic [fml_depth-1:VGAFB_BURST_SHIFT]  base_q;
    logic [18:0]                           burst_cnt;
    logic [18:0]                           nb_q;
    logic [1:0]                            beat;
    logic                                  restart;

    logic        space_ok;
    logic        restart_due;
    logic        last_beat;
    logic [18:0] burst_next;
    logic        unused_base;

    assign space_ok    = (fifo_level <= LEVEL_MAX);
    assign restart_due = restart | frame_start;
    assign last_beat   = (beat == 2'(VGAFB_BURST_WORDS - 1));
    assign burst_next  = burst_cnt + 19'd1;
    assign busy        = (state != IDLE);

    assign fml_adr = {base_q, {VGAFB_BURST_SHIFT{1'b0}}}
                   + (fml_depth'(burst_cnt) << VGAFB_BURST_SHIFT);

    assign unused_base = ^{baseaddress[31:fml_depth], baseaddress[VGAFB_BURST_SHIFT-1:0]};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state           <= IDLE;
            base_q          <= '0;
            burst_cnt       <= '0;
            nb_q            <= '0;
            beat            <= '0;
            restart         <= 1'b0;
            fml_stb         <= 1'b0;
            fifo_we         <= 1'b0;
            baseaddress_ack <= 1'b0;
        end else begin
            baseaddress_ack <= 1'b0;
            // A frame pulse arriving mid-frame is remembered; repeats collapse.
            if (frame_start && (state != IDLE)) begin
                restart <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (frame_start && !vga_rst) begin
                        base_q          <= baseaddress[fml_depth-1:VGAFB_BURST_SHIFT];
                        nb_q            <= nbursts;
                        burst_cnt       <= '0;
                        baseaddress_ack <= 1'b1;
                        state           <= (nbursts == '0) ? IDLE : WAIT_SPACE;
                    end
                end

                WAIT_SPACE: begin
                    if (vga_rst) begin
                        restart <= 1'b0;
                        state   <= IDLE;
                    end else if (space_ok) begin
                        fml_stb <= 1'b1;
                        state   <= REQ;
                    end
                end

                REQ: begin
                    if (fml_ack) begin
                        fml_stb <= 1'b0;
                        fifo_we <= 1'b1;
                        beat    <= '0;
                        state   <= DATA;
                    end
                end

                DATA: begin
                    if (!last_beat) begin
                        beat <= beat + 2'd1;
                    end else begin
                        fifo_we   <= 1'b0;
                        burst_cnt <= burst_next;
                        restart   <= 1'b0;
                        if (vga_rst) begin
                            state <= IDLE;
                        end else if (restart_due) begin
                            // Underrun recovery: reload the frame instead of continuing.
                            base_q          <= baseaddress[fml_depth-1:VGAFB_BURST_SHIFT];
                            nb_q            <= nbursts;
                            burst_cnt       <= '0;
                            baseaddress_ack <= 1'b1;
                            state           <= (nbursts == '0) ? IDLE : WAIT_SPACE;
                        end else if (burst_next == nb_q) begin
                            state <= IDLE;
                        end else begin
                            state <= WAIT_SPACE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef VGAFB_FETCH_STATS_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst || stats_clr) begin
            underruns <= '0;
        end else if (frame_start && (state != IDLE) && (underruns != 16'hFFFF)) begin
            underruns <= underruns + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vgafb_fetch_sched.sv
// tb/tb_vgafb_fetch_sched.sv - directed table-driven bench for vgafb_fetch_sched
module tb_vgafb_fetch_sched;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        vga_rst;
    logic        frame_start;
    logic [31:0] baseaddress;
    logic        baseaddress_ack;
    logic [18:0] nbursts;
    logic [25:0] fml_adr;
    logic        fml_stb;
    logic        fml_ack;
    logic [6:0]  fifo_level;
    logic        fifo_we;
    logic        busy;
`ifdef VGAFB_FETCH_STATS_EN
    logic        stats_clr;
    logic [15:0] underruns;
`endif

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    vgafb_fetch_sched dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .vga_rst         (vga_rst),
        .frame_start     (frame_start),
        .baseaddress     (baseaddress),
        .baseaddress_ack (baseaddress_ack),
        .nbursts         (nbursts),
        .fml_adr         (fml_adr),
        .fml_stb         (fml_stb),
        .fml_ack         (fml_ack),
        .fifo_level      (fifo_level),
        .fifo_we         (fifo_we),
`ifdef VGAFB_FETCH_STATS_EN
        .stats_clr       (stats_clr),
        .underruns       (underruns),
`endif
        .busy            (busy)
    );

    typedef struct {
        logic [31:0] base;
        logic [18:0] nb;
        int          bursts;
        logic [25:0] adr [4];
    } frame_vec_t;

    frame_vec_t vecs [5];

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_frame(input logic [31:0] b, input logic [18:0] n);
        baseaddress = b;
        nbursts     = n;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic do_reset;
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
    endtask

    initial begin
        int  nstb;
        int  nwe;
        int  cyc;
        int  last_ack;
        int  n;
        logic bad;

        sys_rst     = 1'b1;
        vga_rst     = 1'b0;
        frame_start = 1'b0;
        baseaddress = '0;
        nbursts     = '0;
        fml_ack     = 1'b0;
        fifo_level  = '0;
`ifdef VGAFB_FETCH_STATS_EN
        stats_clr   = 1'b0;
`endif

        vecs[0].base = 32'h0010_0040; vecs[0].nb = 19'd3; vecs[0].bursts = 3;
        vecs[0].adr  = '{26'h010_0040, 26'h010_0060, 26'h010_0080, 26'h0};
        vecs[1].base = 32'h03FF_FFE0; vecs[1].nb = 19'd2; vecs[1].bursts = 2;
        vecs[1].adr  = '{26'h3FF_FFE0, 26'h000_0000, 26'h0, 26'h0};
        vecs[2].base = 32'h0000_0000; vecs[2].nb = 19'd0; vecs[2].bursts = 0;
        vecs[2].adr  = '{26'h0, 26'h0, 26'h0, 26'h0};
        vecs[3].base = 32'hFFF0_001F; vecs[3].nb = 19'd1; vecs[3].bursts = 1;
        vecs[3].adr  = '{26'h3F0_0000, 26'h0, 26'h0, 26'h0};
        vecs[4].base = 32'h0000_1234; vecs[4].nb = 19'd4; vecs[4].bursts = 4;
        vecs[4].adr  = '{26'h000_1220, 26'h000_1240, 26'h000_1260, 26'h000_1280};

        // Reset state
        tick();
        tick();
        sys_rst = 1'b0;
        chk_bit("rst stb", fml_stb, 1'b0);
        chk_bit("rst we", fifo_we, 1'b0);
        chk_bit("rst ack", baseaddress_ack, 1'b0);
        chk_bit("rst busy", busy, 1'b0);
        chk_val("rst adr", 32'(fml_adr), 32'h0);

        // Table-driven frames with an always-ready FIFO and immediate acks
        for (int i = 0; i < 5; i++) begin
            start_frame(vecs[i].base, vecs[i].nb);
            chk_bit($sformatf("v%0d ack", i), baseaddress_ack, 1'b1);
            chk_bit($sformatf("v%0d busy", i), busy, vecs[i].bursts != 0);
            nstb = 0;
            nwe = 0;
            cyc = 0;
            last_ack = 0;
            while (cyc < 300 && (busy || fml_stb || fifo_we)) begin
                if (fml_stb) begin
                    if (nstb < 4)
                        chk_val($sformatf("v%0d adr%0d", i, nstb), 32'(fml_adr), 32'(vecs[i].adr[nstb]));
                    chk_val($sformatf("v%0d stb cycle%0d", i, nstb), cyc, (nstb == 0) ? 1 : last_ack + 6);
                    fml_ack = 1'b1;
                    last_ack = cyc;
                    nstb++;
                end
                if (fifo_we) nwe++;
                tick();
                fml_ack = 1'b0;
                cyc++;
            end
            chk_bit($sformatf("v%0d no timeout", i), cyc < 300, 1'b1);
            chk_val($sformatf("v%0d bursts", i), nstb, vecs[i].bursts);
            chk_val($sformatf("v%0d we count", i), nwe, 4 * vecs[i].bursts);
            tick();
            chk_bit($sformatf("v%0d ack low", i), baseaddress_ack, 1'b0);
            chk_bit($sformatf("v%0d idle", i), busy, 1'b0);
        end

        // Back-pressure: 60 and 57 block, 56 releases
        fifo_level = 7'd60;
        start_frame(32'h0020_0000, 19'd1);
        chk_bit("bp ack", baseaddress_ack, 1'b1);
        bad = 1'b0;
        repeat (3) begin
            tick();
            if (fml_stb) bad = 1'b1;
        end
        fifo_level = 7'd57;
        repeat (3) begin
            tick();
            if (fml_stb) bad = 1'b1;
        end
        chk_bit("bp stb held off", bad, 1'b0);
        fifo_level = 7'd56;
        tick();
        chk_bit("bp stb released", fml_stb, 1'b1);
        chk_val("bp adr", 32'(fml_adr), 32'h0020_0000);
        fml_ack = 1'b1;
        tick();
        fml_ack = 1'b0;
        n = 0;
        while (busy && n < 10) begin
            tick();
            n++;
        end
        chk_bit("bp idle", busy, 1'b0);
        fifo_level = '0;

        // vga_rst asserted while a request waits for its ack
        start_frame(32'h0000_0100, 19'd3);
        tick();
        chk_bit("vr stb", fml_stb, 1'b1);
        vga_rst = 1'b1;
        bad = 1'b0;
        repeat (5) begin
            tick();
            if (fml_stb !== 1'b1 || fml_adr !== 26'h000_0100) bad = 1'b1;
        end
        chk_bit("vr stb held stable", bad, 1'b0);
        fml_ack = 1'b1;
        tick();
        fml_ack = 1'b0;
        nwe = 0;
        repeat (8) begin
            if (fifo_we) nwe++;
            tick();
        end
        chk_val("vr beats", nwe, 4);
        chk_bit("vr idle", busy, 1'b0);
        start_frame(32'h0000_0200, 19'd2);
        chk_bit("vr frame ignored ack", baseaddress_ack, 1'b0);
        chk_bit("vr frame ignored busy", busy, 1'b0);
        tick();
        chk_bit("vr frame ignored stb", fml_stb, 1'b0);
        vga_rst = 1'b0;

        // Underrun: second frame_start during the first burst
        do_reset();
        start_frame(32'h0030_0000, 19'd10);
        tick();
        chk_val("ur adr0", 32'(fml_adr), 32'h0030_0000);
        fml_ack = 1'b1;
        tick();
        fml_ack = 1'b0;
        nwe = fifo_we ? 1 : 0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n = 0;
        while (!baseaddress_ack && n < 12) begin
            if (fifo_we) nwe++;
            tick();
            n++;
        end
        chk_bit("ur reload ack", baseaddress_ack, 1'b1);
        chk_val("ur beats before reload", nwe, 4);
        chk_bit("ur busy", busy, 1'b1);
        tick();
        chk_bit("ur stb", fml_stb, 1'b1);
        chk_val("ur adr back to base", 32'(fml_adr), 32'h0030_0000);
`ifdef VGAFB_FETCH_STATS_EN
        chk_val("ur underruns", 32'(underruns), 32'd1);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk_val("ur underruns cleared", 32'(underruns), 32'd0);
`endif
        do_reset();

        // sys_rst during the second data beat abandons the burst
        start_frame(32'h0050_0000, 19'd2);
        tick();
        fml_ack = 1'b1;
        tick();
        fml_ack = 1'b0;
        chk_bit("rd beat0 we", fifo_we, 1'b1);
        tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk_bit("rd we", fifo_we, 1'b0);
        chk_bit("rd stb", fml_stb, 1'b0);
        chk_bit("rd busy", busy, 1'b0);
        chk_val("rd adr", 32'(fml_adr), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
